// File: rtl/rv2t_decode_stage_buffered.sv
// Purpose : RV32I/M decode stage with valid/ready on both sides, 2-entry skid buffer.
// Latency : 1 cycle from input acceptance to out_valid when empty; 1 instr/cycle sustained.
// Backpr. : in_ready drops only when both output and skid hold words (registered, no out_ready path).
//
// Ports:
//   clk, reset_n (async active-low), sync_reset (synchronous flush)
//   in_valid/in_ready, IR_in, PC_in       : fetch side
//   out_valid/out_ready, IR_out, PC_out   : execute side
//   rs1, rs2, csr                         : fields sliced from IR_out
//   ctl[18:0], illegal                    : registered decode of IR_out
//   csr_read_enable                       : out_valid & SYSTEM & CSR
module rv2t_decode_stage_buffered #(
  parameter int XLEN           = 32,
  parameter int PC_BITWIDTH    = 32,
  parameter int REG_ADDR_BITS  = 5,
  parameter int ENABLE_MUL_DIV = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          IR_in,
  input  logic [PC_BITWIDTH-1:0]   PC_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          IR_out,
  output logic [PC_BITWIDTH-1:0]   PC_out,
  output logic [REG_ADDR_BITS-1:0] rs1,
  output logic [REG_ADDR_BITS-1:0] rs2,
  output logic [11:0]              csr,
  output logic                     csr_read_enable,
  output logic [18:0]              ctl,
  output logic                     illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [XLEN-1:0]        ir_q, ir_d;
  logic [PC_BITWIDTH-1:0] pc_q, pc_d;
  logic [18:0]            ctl_q, ctl_d;
  logic                   ill_q, ill_d;
  logic [XLEN-1:0]        skid_ir_q, skid_ir_d;
  logic [PC_BITWIDTH-1:0] skid_pc_q, skid_pc_d;

  logic                   acc_in, acc_out;
  logic                   load_out, load_from_skid, load_skid;
  logic [XLEN-1:0]        src_ir;
  logic [PC_BITWIDTH-1:0] src_pc;
  logic [19:0]            dec;

  // Returns {illegal, ctl}; ctl is forced to zero for any illegal word.
  function automatic logic [19:0] decode_fn(input logic [XLEN-1:0] ir);
    logic [18:0] c;
    logic        ill;
    logic [2:0]  f3;
    c   = '0;
    ill = 1'b0;
    f3  = ir[14:12];
    if (ir[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (ir[6:2])
        5'b00100: begin c[0] = 1'b1; c[2] = 1'b1; c[3] = 1'b1; c[4] = 1'b1; end
        5'b01100: begin
          if (ir[25] && (ENABLE_MUL_DIV == 0)) begin
            ill = 1'b1;
          end else begin
            c[0] = 1'b1; c[1] = 1'b1; c[3] = 1'b1;
            c[4] = ~ir[25];
            c[5] = ir[25];
          end
        end
        5'b01101: begin c[6] = 1'b1; c[3] = 1'b1; end
        5'b00101: begin c[7] = 1'b1; c[3] = 1'b1; end
        5'b11011: begin c[8] = 1'b1; c[3] = 1'b1; end
        5'b11001: begin c[9] = 1'b1; c[3] = 1'b1; c[0] = 1'b1; end
        5'b11000: begin c[10] = 1'b1; c[0] = 1'b1; c[1] = 1'b1; end
        5'b00000: begin c[11] = 1'b1; c[0] = 1'b1; end
        5'b01000: begin c[12] = 1'b1; c[0] = 1'b1; c[1] = 1'b1; end
        5'b00011: begin c[16] = 1'b1; end
        5'b11100: begin
          if (f3 == 3'b100) begin
            ill = 1'b1;
          end else begin
            c[13] = 1'b1;
            c[0]  = 1'b1;
            if ((f3 == 3'b000) && (ir[24:20] == 5'b00010)) begin
              c[17] = 1'b1;
            end else if ((f3 == 3'b000) && (ir[24:20] == 5'b00101)) begin
              c[18] = 1'b1;
            end else begin
              c[14] = |f3;
              c[3]  = |f3;
              c[15] = |ir[19:15];
            end
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) c = '0;
    return {ill, c};
  endfunction

  // Flush cycle refuses input so a discarded word is never half-accepted.
  assign in_ready = in_ready_q & ~sync_reset;
  assign acc_in   = in_valid & in_ready;
  assign acc_out  = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    load_out       = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (sync_reset) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_in) begin
            state_d  = ST_ONE;
            load_out = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc_in && acc_out) begin
            load_out = 1'b1;
          end else if (acc_in) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (acc_out) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (acc_out) begin
            state_d        = ST_ONE;
            load_out       = 1'b1;
            load_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Decode is applied to whichever word is about to enter the output register.
  always_comb begin
    src_ir = load_from_skid ? skid_ir_q : IR_in;
    src_pc = load_from_skid ? skid_pc_q : PC_in;
    dec    = decode_fn(src_ir);

    ir_d      = load_out  ? src_ir     : ir_q;
    pc_d      = load_out  ? src_pc     : pc_q;
    ctl_d     = load_out  ? dec[18:0]  : ctl_q;
    ill_d     = load_out  ? dec[19]    : ill_q;
    skid_ir_d = load_skid ? IR_in      : skid_ir_q;
    skid_pc_d = load_skid ? PC_in      : skid_pc_q;

    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ir_q        <= '0;
      pc_q        <= '0;
      ctl_q       <= '0;
      ill_q       <= 1'b0;
      skid_ir_q   <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      ctl_q       <= ctl_d;
      ill_q       <= ill_d;
      skid_ir_q   <= skid_ir_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign IR_out          = ir_q;
  assign PC_out          = pc_q;
  assign ctl             = ctl_q;
  assign illegal         = ill_q;
  assign rs1             = ir_q[15 +: REG_ADDR_BITS];
  assign rs2             = ir_q[20 +: REG_ADDR_BITS];
  assign csr             = ir_q[31:20];
  assign csr_read_enable = out_valid_q & ctl_q[13] & ctl_q[14];

endmodule

// File: doc/rv2t_decode_stage_buffered.md
Name: rv2t_decode_stage_buffered

Overview:
- Parametrised successor to the RV2T instruction decoder.
- Decodes RV32I/M instructions into a registered control bundle and adds a valid/ready handshake on both sides, backed by a 2-entry skid buffer.
- Flags illegal instructions and supports a synchronous flush.
- Sits between instruction fetch and execute; fetch back-pressure comes from the buffer, not from a global decode_enable.

Parameters:
- XLEN, 32, instruction/data width.
- PC_BITWIDTH, 32, program counter width.
- REG_ADDR_BITS, 5, register address width.
- ENABLE_MUL_DIV, 1, when 1 the M-extension encodings decode; when 0 they are illegal.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous flush, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept an instruction
- IR_in  in  XLEN  instruction word
- PC_in  in  PC_BITWIDTH  instruction PC
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts it
- IR_out  out  XLEN  registered instruction
- PC_out  out  PC_BITWIDTH  registered PC
- rs1  out  REG_ADDR_BITS  IR_out[19:15]
- rs2  out  REG_ADDR_BITS  IR_out[24:20]
- csr  out  12  IR_out[31:20]
- csr_read_enable  out  1  out_valid & ctl[13] & ctl[14]
- ctl  out  19  registered control bundle, bit order below
- illegal  out  1  registered illegal-instruction flag

Behaviour:
- ctl bits:
  - 0 load_X_from_rs1, 1 load_Y_from_rs2, 2 load_Y_from_imm_12, 3 save_to_rd
  - 4 ALU_FUNCT3, 5 MUL_DIV_FUNCT3, 6 LUI, 7 AUIPC, 8 JAL, 9 JALR
  - 10 BRANCH, 11 LOAD, 12 STORE, 13 SYSTEM, 14 CSR, 15 CSR_write
  - 16 MISC_MEM, 17 MRET, 18 WFI
- Decode is combinational on the word entering the output register (from IR_in or the skid); the result is registered together with IR/PC. ctl always matches IR_out.
- Decode by IR[6:2]:
  - OP_IMM 00100: bits 0,2,3,4.
  - OP 01100: bits 0,1,3; bit4 = ~IR[25]; bit5 = IR[25].
  - LUI 01101: bits 6,3.
  - AUIPC 00101: bits 7,3.
  - JAL 11011: bits 8,3.
  - JALR 11001: bits 9,3,0.
  - BRANCH 11000: bits 10,0,1.
  - LOAD 00000: bits 11,0 (no save_to_rd).
  - STORE 01000: bits 12,0,1.
  - MISC_MEM 00011: bit 16.
  - SYSTEM 11100: bits 13,0. If funct3=0 and IR[24:20]=00010, MRET. Else if funct3=0 and IR[24:20]=00101, WFI. Otherwise CSR = |funct3. save_to_rd = CSR; CSR_write = |IR[19:15].
- Illegal (illegal=1, ctl=0, IR/PC still forwarded):
  - IR[1:0] != 11
  - unlisted opcode
  - SYSTEM with funct3=100
  - OP with IR[25]=1 when ENABLE_MUL_DIV=0
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: output register valid, in_ready=1.
  - TWO: output and skid valid, in_ready=0.
  - in_ready is decoded from state only, with no combinational path from out_ready.
- Transitions (acc_in = in_valid & in_ready; acc_out = out_valid & out_ready):
  - EMPTY + acc_in -> ONE.
  - ONE + acc_in & acc_out -> ONE, output register loads the new word.
  - ONE + acc_in only -> TWO, word goes to skid.
  - ONE + acc_out only -> EMPTY.
  - TWO + acc_out -> ONE, skid moves to output.
- Latency: 1 cycle from acc_in to out_valid when EMPTY. Sustained throughput is 1 per cycle.
- Output registers hold stable while out_valid & ~out_ready.
- Reset (reset_n=0): state EMPTY; IR_out, PC_out, ctl, illegal, skid all 0; in_ready=1 after release.
- sync_reset: next state EMPTY and all held words discarded. in_ready=0 during the asserted cycle; the input is not accepted. Flush overrides any simultaneous acc_in/acc_out.

Test Plan:
- Reset, then IR_in=0x00500093 (addi x1,x0,5), PC_in=0x100, out_ready=1 -> next cycle out_valid=1, ctl=0x001D, rs1=0, illegal=0.
- Stream 4 back-to-back instructions with out_ready=1 -> 4 consecutive out_valid cycles, order and PCs preserved, in_ready stays 1.
- out_ready=0, feed 2 instructions -> state TWO, in_ready=0. Third is held off. Raise out_ready -> words emerge in order, no loss or duplication.
- ENABLE_MUL_DIV=0, IR=0x02208033 (mul) -> illegal=1, ctl=0. With ENABLE_MUL_DIV=1 -> ctl=0x002B.
- SYSTEM: 0x30200073 (mret) -> ctl bits 13,17,0 set, csr_read_enable=0. 0x300110F3 (csrrw x1,mstatus,x2) -> bits 13,14,3,0 set; bit15=1 because rs1=x2 (nonzero), so ctl=0xE009; csr_read_enable=1.
- In state TWO, assert sync_reset together with out_ready and in_valid -> next cycle EMPTY, out_valid=0, nothing accepted. Async reset mid-stream -> all outputs 0 immediately.
